// File: rtl/seg7_pkg.sv
// Shared types and seven-segment patterns for the BCD counter display.
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Non-decimal nibbles cannot be held by a digit; they map to blank.
  function automatic logic [6:0] seg_decode(input bcd_t d);
    case (d)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_bcd_counter_digit.sv
// One decade digit: steps when en & cin, carry/borrow out is combinational so
// a whole chain of digits ripples within a single cycle.
module bcd_digit
  import seg7_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic up,
  input  logic cin,
  input  logic load,
  input  logic clr,
  input  bcd_t load_val,
  output bcd_t value,
  output logic cout
);

  logic step;

  assign step = en & cin;
  assign cout = step & (up ? (value == 4'd9) : (value == 4'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (load) begin
      value <= (load_val > 4'd9) ? '0 : load_val;
    end else if (step) begin
      if (up) value <= (value == 4'd9) ? '0 : value + 4'd1;
      else    value <= (value == 4'd0) ? 4'd9 : value - 4'd1;
    end
  end

endmodule

// File: rtl/seg7_bcd_counter.sv
// Multi-digit BCD up/down counter with prescaled tick and multiplexed 7-seg scan.
// Optional: SEG7_LEADING_ZERO_BLANK_EN blanks leading-zero digits (digit 0 never).
module seg7_bcd_counter
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 12000000,
  parameter int SCAN_DIV = 12000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                up,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                wrap,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = en && (pre_cnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  pre_cnt <= '0;
    else if (en) pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
  end

  bcd_t        digit [DIGITS];
  logic [DIGITS:0] chain;

  assign chain[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (tick),
      .up       (up),
      .cin      (chain[i]),
      .load     (load),
      .clr      (clr),
      .load_val (load_val[4*i +: 4]),
      .value    (digit[i]),
      .cout     (chain[i+1])
    );
  end

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < DIGITS; i++) count[4*i +: 4] = digit[i];
  end

  // Carry out of the top digit is exactly the all-9/all-0 wrap, suppressed when clr/load win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap <= 1'b0;
    else        wrap <= chain[DIGITS] & ~clr & ~load;
  end

  logic [SW-1:0] div_cnt;
  logic [IW-1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (div_cnt == SW'(SCAN_DIV - 1)) begin
      div_cnt <= '0;
      idx     <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      div_cnt <= div_cnt + SW'(1);
    end
  end

  bcd_t              sel_digit;
  logic              blank;
  logic [DIGITS-1:0] an_next;
  logic [6:0]        seg_next;

  always_comb begin
    sel_digit = '0;
    an_next   = '0;
    blank     = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        sel_digit  = digit[i];
        an_next[i] = 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blank = (i != 0) && ((count >> (4*i)) == '0);
`endif
      end
    end
    seg_next = blank ? SEG_BLANK : seg_decode(sel_digit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= DIGITS'(1);
      seg <= SEG_0;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_bcd_counter.sv
// Bench for seg7_bcd_counter: arithmetic reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_seg7_bcd_counter;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;
  localparam int SCAN_DIV = 2;
  localparam int MOD      = 10000;

  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h00;
`else
  localparam logic [6:0] LZ_SEG = 7'h3F;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        up = 1'b1;
  logic        clr = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] count;
  logic        wrap;
  logic [6:0]  seg;
  logic [3:0]  an;

  int asserts  = 0;
  int failures = 0;
  bit chk_on   = 1'b0;
  bit wrap_seen;

  always #5 clk = ~clk;

  seg7_bcd_counter #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .wrap     (wrap),
    .seg      (seg),
    .an       (an)
  );

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((n / pow10(i)) % 10);
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] v);
    int s = 0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] <= 4'd9) s += int'(v[4*i +: 4]) * pow10(i);
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: value as a plain integer modulo 10^DIGITS, scan slot from cycle count.
  int         m_n, m_pre, m_cyc;
  logic       m_wrap;
  logic [3:0] m_an;
  logic [6:0] m_seg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n <= 0; m_pre <= 0; m_cyc <= 0; m_wrap <= 1'b0;
      m_an <= 4'd1; m_seg <= SEG_TAB[0];
    end else begin
      int   slot, above, n, pre;
      bit   tk, w;
      logic [6:0] s;
      slot  = (m_cyc / SCAN_DIV) % DIGITS;
      above = m_n / pow10(slot);
      s     = SEG_TAB[above % 10];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (slot != 0 && above == 0) s = 7'h00;
`endif
      tk  = en && (m_pre == PRESCALE - 1);
      pre = en ? (tk ? 0 : m_pre + 1) : m_pre;
      n   = m_n;
      w   = 1'b0;
      if (clr)       n = 0;
      else if (load) n = from_load(load_val);
      else if (tk) begin
        if (up) begin w = (m_n == MOD - 1); n = (m_n + 1) % MOD; end
        else    begin w = (m_n == 0);       n = (m_n + MOD - 1) % MOD; end
      end
      m_an   <= 4'(1 << slot);
      m_seg  <= s;
      m_pre  <= pre;
      m_n    <= n;
      m_wrap <= w;
      m_cyc  <= m_cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_count", count, to_bcd(m_n));
      check("model_wrap",  wrap,  m_wrap);
      check("model_an",    an,    m_an);
      check("model_seg",   seg,   m_seg);
      if (wrap) wrap_seen = 1'b1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    en = 1'b0; clr = 1'b0; load = 1'b0; up = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  localparam logic [3:0] SCAN_AN  [4] = '{4'd2, 4'd4, 4'd8, 4'd1};
  localparam logic [6:0] SCAN_SEG [4] = '{7'h4F, 7'h5B, 7'h06, 7'h66};

  initial begin
    cyc(2);
    check("reset_count", count, 16'h0000);
    check("reset_an",    an,    4'd1);
    check("reset_seg",   seg,   7'h3F);
    check("reset_wrap",  wrap,  1'b0);
    #2 rst_n = 1'b1;
    chk_on = 1'b1;

    // 40 enabled cycles at PRESCALE=4 -> 10 ticks
    en = 1'b1; up = 1'b1; wrap_seen = 1'b0;
    cyc(40);
    check("count_up_10", count, 16'h0010);
    check("no_wrap_up_10", wrap_seen, 1'b0);

    do_reset();
    load_val = 16'h9998; load = 1'b1;
    cyc(1);
    check("load_9998", count, 16'h9998);
    load = 1'b0; en = 1'b1;
    cyc(4);
    check("up_9999", count, 16'h9999);
    check("up_9999_wrap", wrap, 1'b0);
    cyc(4);
    check("up_wrap_0000", count, 16'h0000);
    check("up_wrap_pulse", wrap, 1'b1);
    cyc(1);
    check("up_wrap_one_cycle", wrap, 1'b0);

    do_reset();
    en = 1'b1; up = 1'b0;
    cyc(4);
    check("down_9999", count, 16'h9999);
    check("down_wrap_pulse", wrap, 1'b1);
    en = 1'b0; load_val = 16'h12A4; load = 1'b1;
    cyc(1);
    check("load_invalid_nibble", count, 16'h1204);
    load = 1'b0;

    do_reset();
    en = 1'b1; up = 1'b1;
    cyc(3);
    load_val = 16'h0500; load = 1'b1;
    cyc(1);
    check("load_beats_tick", count, 16'h0500);
    load = 1'b0;
    cyc(3);
    check("hold_after_load", count, 16'h0500);
    cyc(1);
    check("tick_after_load", count, 16'h0501);
    clr = 1'b1; load = 1'b1; load_val = 16'h4321;
    cyc(1);
    check("clr_beats_load", count, 16'h0000);
    check("clr_no_wrap", wrap, 1'b0);
    clr = 1'b0; load = 1'b0;

    do_reset();
    load_val = 16'h1234; load = 1'b1;
    cyc(1);
    load = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cyc(2);
      check("scan_1234_an",  an,  SCAN_AN[j]);
      check("scan_1234_seg", seg, SCAN_SEG[j]);
    end

    do_reset();
    load_val = 16'h0007; load = 1'b1;
    cyc(1);
    load = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cyc(2);
      check("scan_0007_an",  an,  SCAN_AN[j]);
      check("scan_0007_seg", seg, (j == 3) ? 7'h07 : LZ_SEG);
    end

    do_reset();
    en = 1'b1; up = 1'b1;
    cyc(9);
    check("pre_reset_count", count, 16'h0002);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_count", count, 16'h0000);
    check("async_reset_an",    an,    4'd1);
    check("async_reset_seg",   seg,   7'h3F);
    check("async_reset_wrap",  wrap,  1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cyc(3);
    check("no_tick_before_prescale", count, 16'h0000);
    cyc(1);
    check("first_tick_after_reset", count, 16'h0001);
    en = 1'b0;
    cyc(50);
    check("en_low_holds", count, 16'h0001);

    cyc(1);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
